axi4_lite_master: RTL and testbench

//  Initiator end of the AXI4-Lite link: converts single-beat user commands into AXI4-Lite read/write

---
 rtl/axi4_lite_pkg.sv | 18 +
 rtl/axi4_lite_master_if.sv | 40 ++++
 rtl/axi4_lite_master_wr_tracker.sv | 75 +++++++
 rtl/axi4_lite_master.sv | 193 +++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encoding and response codes.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_WRESP = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle: the five channels between master and slave.
interface axi4_lite_master_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR;
    logic                      M_AXI_AWVALID;
    logic                      M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]     M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB;
    logic                      M_AXI_WVALID;
    logic                      M_AXI_WREADY;
    logic [1:0]                M_AXI_BRESP;
    logic                      M_AXI_BVALID;
    logic                      M_AXI_BREADY;
    logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR;
    logic                      M_AXI_ARVALID;
    logic                      M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]     M_AXI_RDATA;
    logic [1:0]                M_AXI_RRESP;
    logic                      M_AXI_RVALID;
    logic                      M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
    );

endinterface

// File: rtl/axi4_lite_master_wr_tracker.sv
// Tracks the AW and W channels of one write: both valids rise together on
// start, each drops after its own handshake, and both_done flags the edge at
// which the second (or both) handshakes complete.
module axi4_lite_master_wr_tracker (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic start,
    input  logic abort,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q, w_done_d;
    logic aw_hs, w_hs;

    // Next-state of valids and done flags; a handshake this edge counts as done.
    always_comb begin
        aw_hs     = awvalid_q && awready;
        w_hs      = wvalid_q && wready;
        both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else if (start) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                awvalid_d = 1'b0;
                aw_done_d = 1'b1;
            end
            if (w_hs) begin
                wvalid_d = 1'b0;
                w_done_d = 1'b1;
            end
            if (both_done) begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        end
    end

    // Flag registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;

endmodule

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one user command at a time becomes one AXI read or
// write; the captured data/response is held on rsp_* until accepted.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | cmd_ready=1, waiting for a user command
//   ST_RADDR | ARVALID high, waiting for ARREADY
//   ST_RDATA | RREADY high, waiting for RVALID
//   ST_WRITE | AW/W in flight, waiting for both handshakes
//   ST_WRESP | BREADY high, waiting for BVALID
//   ST_RESP  | rsp_valid high, waiting for rsp_ready
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    axi4_lite_master_if.master        m_axi
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  araddr_q, araddr_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic                      bready_q, bready_d;
    logic [ADDRESS_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      wr_start, wr_abort, wr_both_done;
    logic                      wr_awvalid, wr_wvalid;

    axi4_lite_master_wr_tracker u_wr_tracker (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (wr_start),
        .abort     (wr_abort),
        .awready   (m_axi.M_AXI_AWREADY),
        .wready    (m_axi.M_AXI_WREADY),
        .awvalid   (wr_awvalid),
        .wvalid    (wr_wvalid),
        .both_done (wr_both_done)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wr_start    = 1'b0;
        wr_abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d = cmd_addr;
                        wdata_d  = cmd_wdata;
                        wstrb_d  = cmd_wstrb;
                        wr_start = 1'b1;
                        state_d  = ST_WRITE;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_RADDR: begin
                if (arvalid_q && m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (rready_q && m_axi.M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi.M_AXI_RDATA;
                    rsp_resp_d  = m_axi.M_AXI_RRESP;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                if (wr_both_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bready_q && m_axi.M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi.M_AXI_BRESP;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encodings fall back to idle with the bus quiet.
                state_d     = ST_IDLE;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                bready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                wr_abort    = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWVALID = wr_awvalid;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wr_wvalid;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a 32-word memory slave model
// with programmable AW/W ready stalls and forced read response code.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        ACLK;
    logic        ARESETN;
    logic        cmd_valid, cmd_write, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int errors, checks;

    axi4_lite_master_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_axi     (bus)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // ---------------- slave model ----------------
    int          aw_delay, w_delay;
    logic [1:0]  rresp_force;
    logic [31:0] mem [32];
    logic        aw_got, w_got, bvalid, rvalid;
    logic [4:0]  aw_idx;
    logic [31:0] w_data, rdata;
    logic [3:0]  w_strb;
    logic [1:0]  rresp;
    int          aw_cnt, w_cnt;
    logic        aw_hs, w_hs, commit;
    logic [4:0]  idx_eff;
    logic [31:0] data_eff;
    logic [3:0]  strb_eff;
    int          aw_hs_cnt, w_hs_cnt, b_hs_cnt, rsp_cnt, aw_linger, w_linger;

    assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_delay);
    assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && !w_got && (w_cnt >= w_delay);
    assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && !rvalid;
    assign bus.M_AXI_BVALID  = bvalid;
    assign bus.M_AXI_BRESP   = RESP_OKAY;
    assign bus.M_AXI_RVALID  = rvalid;
    assign bus.M_AXI_RDATA   = rdata;
    assign bus.M_AXI_RRESP   = rresp;

    assign aw_hs    = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
    assign w_hs     = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
    assign commit   = (aw_got || aw_hs) && (w_got || w_hs);
    assign idx_eff  = aw_hs ? bus.M_AXI_AWADDR[4:0] : aw_idx;
    assign data_eff = w_hs ? bus.M_AXI_WDATA : w_data;
    assign strb_eff = w_hs ? bus.M_AXI_WSTRB : w_strb;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; aw_idx <= '0; w_data <= '0; w_strb <= '0;
            rdata <= '0; rresp <= '0;
        end else begin
            aw_cnt <= (aw_hs || !bus.M_AXI_AWVALID) ? 0 : aw_cnt + 1;
            w_cnt  <= (w_hs || !bus.M_AXI_WVALID) ? 0 : w_cnt + 1;
            if (bvalid && bus.M_AXI_BREADY) bvalid <= 1'b0;
            if (commit) begin
                for (int b = 0; b < 4; b++)
                    if (strb_eff[b]) mem[idx_eff][b*8 +: 8] <= data_eff[b*8 +: 8];
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bvalid <= 1'b1;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_idx <= bus.M_AXI_AWADDR[4:0]; end
                if (w_hs) begin w_got <= 1'b1; w_data <= bus.M_AXI_WDATA; w_strb <= bus.M_AXI_WSTRB; end
            end
            if (rvalid && bus.M_AXI_RREADY) rvalid <= 1'b0;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                rvalid <= 1'b1;
                rdata  <= mem[bus.M_AXI_ARADDR[4:0]];
                rresp  <= rresp_force;
            end
        end
    end

    // Handshake / protocol monitors.
    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_hs_cnt <= 0; w_hs_cnt <= 0; b_hs_cnt <= 0; rsp_cnt <= 0;
            aw_linger <= 0; w_linger <= 0;
        end else begin
            if (aw_hs) aw_hs_cnt <= aw_hs_cnt + 1;
            if (w_hs) w_hs_cnt <= w_hs_cnt + 1;
            if (bvalid && bus.M_AXI_BREADY) b_hs_cnt <= b_hs_cnt + 1;
            if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
            if (bus.M_AXI_AWVALID && aw_got) aw_linger <= aw_linger + 1;
            if (bus.M_AXI_WVALID && w_got) w_linger <= w_linger + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 60) begin @(negedge ACLK); cyc++; end
        chk("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic finish_rsp(input string tag);
        @(negedge ACLK);
        chk({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    // One full transaction with payload checks; exp_lat < 0 skips the latency check.
    task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                       input int exp_lat);
        int lat;
        send_cmd(wr, a, d, s);
        wait_rsp(lat);
        if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rsp_write"}, {31'd0, rsp_write}, {31'd0, wr});
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_rsp_resp"}, {30'd0, rsp_resp}, {30'd0, exp_resp});
        finish_rsp(tag);
    endtask

    task automatic stall_write(input string tag, input int awd, input int wd,
                               input logic [31:0] a, input logic [31:0] d);
        int aw0, w0, b0;
        aw_delay = awd; w_delay = wd;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        txn(tag, 1'b1, a, d, 4'hF, 32'h0, RESP_OKAY, -1);
        chk({tag, "_aw_count"}, aw_hs_cnt - aw0, 32'd1);
        chk({tag, "_w_count"}, w_hs_cnt - w0, 32'd1);
        chk({tag, "_b_count"}, b_hs_cnt - b0, 32'd1);
        chk({tag, "_aw_linger"}, aw_linger, 32'd0);
        chk({tag, "_w_linger"}, w_linger, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat, r0;
        errors = 0; checks = 0;
        ARESETN = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        aw_delay = 0; w_delay = 0; rresp_force = RESP_OKAY;
        repeat (3) @(negedge ACLK);

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
        chk("rst_awvalid", {31'd0, bus.M_AXI_AWVALID}, 32'd0);
        chk("rst_wvalid", {31'd0, bus.M_AXI_WVALID}, 32'd0);
        chk("rst_bready", {31'd0, bus.M_AXI_BREADY}, 32'd0);
        chk("rst_rready", {31'd0, bus.M_AXI_RREADY}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
        chk("rst_awaddr", bus.M_AXI_AWADDR, 32'd0);
        chk("rst_araddr", bus.M_AXI_ARADDR, 32'd0);
        chk("rst_wdata", bus.M_AXI_WDATA, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Full-word write then read back, zero-wait slave.
        txn("t1_wr", 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'h0, RESP_OKAY, 2);
        txn("t1_rd", 1'b0, 32'd5, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY, 2);

        // Partial strobe: bytes 0 and 2 replaced.
        txn("t2_wr", 1'b1, 32'd5, 32'h11223344, 4'b0101, 32'h0, RESP_OKAY, 2);
        txn("t2_rd", 1'b0, 32'd5, 32'h0, 4'h0, 32'hDE22BE44, RESP_OKAY, 2);

        // AW/W handshake ordering.
        stall_write("t3_aw_late", 3, 0, 32'd7, 32'hA5A50001);
        stall_write("t3_w_late", 0, 3, 32'd8, 32'hA5A50002);
        stall_write("t3_same", 1, 1, 32'd9, 32'hA5A50003);
        aw_delay = 0; w_delay = 0;
        txn("t3_rd7", 1'b0, 32'd7, 32'h0, 4'h0, 32'hA5A50001, RESP_OKAY, 2);
        txn("t3_rd8", 1'b0, 32'd8, 32'h0, 4'h0, 32'hA5A50002, RESP_OKAY, 2);
        txn("t3_rd9", 1'b0, 32'd9, 32'h0, 4'h0, 32'hA5A50003, RESP_OKAY, 2);

        // Response back-pressure.
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'd5, 32'h0, 4'h0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_hold_rdata", rsp_rdata, 32'hDE22BE44);
            chk("t4_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        finish_rsp("t4");

        // Error response passes through, then normal traffic resumes.
        rresp_force = RESP_SLVERR;
        r0 = rsp_cnt;
        txn("t5_err", 1'b0, 32'd5, 32'h0, 4'h0, 32'hDE22BE44, RESP_SLVERR, 2);
        chk("t5_one_rsp", rsp_cnt - r0, 32'd1);
        rresp_force = RESP_OKAY;
        txn("t5_next", 1'b0, 32'd9, 32'h0, 4'h0, 32'hA5A50003, RESP_OKAY, 2);

        // Reset in the middle of a stalled write.
        aw_delay = 20; w_delay = 20;
        send_cmd(1'b1, 32'd5, 32'hFFFFFFFF, 4'hF);
        repeat (2) @(negedge ACLK);
        chk("t6_in_write_aw", {31'd0, bus.M_AXI_AWVALID}, 32'd1);
        chk("t6_in_write_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("t6_rst_awvalid", {31'd0, bus.M_AXI_AWVALID}, 32'd0);
        chk("t6_rst_wvalid", {31'd0, bus.M_AXI_WVALID}, 32'd0);
        chk("t6_rst_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
        chk("t6_rst_bready", {31'd0, bus.M_AXI_BREADY}, 32'd0);
        chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        ARESETN = 1'b1;
        aw_delay = 0; w_delay = 0;
        @(negedge ACLK);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(negedge ACLK);
        chk("t6_no_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_no_rsp_count", rsp_cnt, 32'd0);
        txn("t6_rd", 1'b0, 32'd5, 32'h0, 4'h0, 32'hDE22BE44, RESP_OKAY, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
